// File: rtl/mf_pkg.sv
// Shared state encoding and width helpers for the time-multiplexed matched filter.
package mf_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE       = 3'd0,
        LOAD_COEFF = 3'd1,
        WAIT_DATA  = 3'd2,
        MAC        = 3'd3,
        MAG        = 3'd4
    } mf_state_t;

    // Sum of N full-precision complex products, each needing DW+CW+1 bits.
    function automatic int acc_width(input int dw, input int cw, input int n);
        return dw + cw + 1 + $clog2(n);
    endfunction

    function automatic int mag_width(input int aw);
        return 2 * aw + 1;
    endfunction

endpackage

// File: rtl/complex_mac.sv
// Registered complex multiply-accumulate: acc += a*b at full precision.
// clr has priority over en; both are synchronous.
module complex_mac #(
    parameter int A_WIDTH   = 18,
    parameter int B_WIDTH   = 18,
    parameter int ACC_WIDTH = 42
) (
    input  logic                        clock,
    input  logic                        resetN,
    input  logic                        clr,
    input  logic                        en,
    input  logic signed [A_WIDTH-1:0]   a_re,
    input  logic signed [A_WIDTH-1:0]   a_im,
    input  logic signed [B_WIDTH-1:0]   b_re,
    input  logic signed [B_WIDTH-1:0]   b_im,
    output logic signed [ACC_WIDTH-1:0] acc_re,
    output logic signed [ACC_WIDTH-1:0] acc_im
);

    localparam int PROD_W = A_WIDTH + B_WIDTH;

    logic signed [PROD_W-1:0]    p_rr;
    logic signed [PROD_W-1:0]    p_ii;
    logic signed [PROD_W-1:0]    p_ri;
    logic signed [PROD_W-1:0]    p_ir;
    logic signed [ACC_WIDTH-1:0] term_re;
    logic signed [ACC_WIDTH-1:0] term_im;

    assign p_rr = PROD_W'(a_re) * PROD_W'(b_re);
    assign p_ii = PROD_W'(a_im) * PROD_W'(b_im);
    assign p_ri = PROD_W'(a_re) * PROD_W'(b_im);
    assign p_ir = PROD_W'(a_im) * PROD_W'(b_re);

    assign term_re = ACC_WIDTH'(p_rr) - ACC_WIDTH'(p_ii);
    assign term_im = ACC_WIDTH'(p_ri) + ACC_WIDTH'(p_ir);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            acc_re <= '0;
            acc_im <= '0;
        end else if (clr) begin
            acc_re <= '0;
            acc_im <= '0;
        end else if (en) begin
            acc_re <= acc_re + term_re;
            acc_im <= acc_im + term_im;
        end
    end

endmodule

// File: rtl/matched_filter_tdm.sv
// Time-multiplexed complex matched filter with run-time coefficient load and |y|^2 output.
// Define MF_PEAK_DETECT_EN to track the largest magnitude and its result index.
//
// state      | meaning
// IDLE       | no coefficients, waiting for coeffLoad
// LOAD_COEFF | accepting coefficient beats h[0..N-1]
// WAIT_DATA  | dataReady high, waiting for a sample
// MAC        | N accumulate cycles over the delay line
// MAG        | register y and |y|^2, pulse outValid
module matched_filter_tdm
    import mf_pkg::*;
#(
    parameter int COEFF_LENGTH = 32,
    parameter int DATA_WIDTH   = 18,
    parameter int COEFF_WIDTH  = 18,
    parameter int ACC_WIDTH    = acc_width(DATA_WIDTH, COEFF_WIDTH, COEFF_LENGTH),
    parameter int MAG_WIDTH    = mag_width(ACC_WIDTH)
) (
    input  logic                          clock,
    input  logic                          resetN,
    input  logic                          coeffLoad,
    input  logic                          coeffValid,
    input  logic signed [COEFF_WIDTH-1:0] coeffInRe,
    input  logic signed [COEFF_WIDTH-1:0] coeffInIm,
    output logic                          coeffSetFlag,
    input  logic                          dataValid,
    output logic                          dataReady,
    input  logic signed [DATA_WIDTH-1:0]  dataInRe,
    input  logic signed [DATA_WIDTH-1:0]  dataInIm,
    output logic                          outValid,
    output logic signed [ACC_WIDTH-1:0]   outRe,
    output logic signed [ACC_WIDTH-1:0]   outIm,
    output logic [MAG_WIDTH-1:0]          outMagSq,
    output logic [MAG_WIDTH-1:0]          peakMag,
    output logic [31:0]                   peakIndex
);

    localparam int              PTR_W = $clog2(COEFF_LENGTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(COEFF_LENGTH - 1);

    mf_state_t state;

    logic signed [COEFF_WIDTH-1:0] coef_re [COEFF_LENGTH];
    logic signed [COEFF_WIDTH-1:0] coef_im [COEFF_LENGTH];
    logic signed [DATA_WIDTH-1:0]  hist_re [COEFF_LENGTH];
    logic signed [DATA_WIDTH-1:0]  hist_im [COEFF_LENGTH];

    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] k_cnt;

    logic                        mac_clr;
    logic                        mac_en;
    logic signed [ACC_WIDTH-1:0] acc_re;
    logic signed [ACC_WIDTH-1:0] acc_im;
    logic signed [MAG_WIDTH-1:0] re_ext;
    logic signed [MAG_WIDTH-1:0] im_ext;
    logic [MAG_WIDTH-1:0]        mag_sq;

    // The accumulator is held clear while idle so MAC always starts from zero.
    assign mac_clr = coeffLoad || (state == WAIT_DATA);
    assign mac_en  = (state == MAC);

    complex_mac #(
        .A_WIDTH  (COEFF_WIDTH),
        .B_WIDTH  (DATA_WIDTH),
        .ACC_WIDTH(ACC_WIDTH)
    ) u_mac (
        .clock (clock),
        .resetN(resetN),
        .clr   (mac_clr),
        .en    (mac_en),
        .a_re  (coef_re[k_cnt]),
        .a_im  (coef_im[k_cnt]),
        .b_re  (hist_re[rd_ptr]),
        .b_im  (hist_im[rd_ptr]),
        .acc_re(acc_re),
        .acc_im(acc_im)
    );

    assign re_ext = MAG_WIDTH'(acc_re);
    assign im_ext = MAG_WIDTH'(acc_im);
    assign mag_sq = MAG_WIDTH'(re_ext * re_ext + im_ext * im_ext);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            idx          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            k_cnt        <= '0;
            coeffSetFlag <= 1'b0;
            dataReady    <= 1'b0;
            outValid     <= 1'b0;
            outRe        <= '0;
            outIm        <= '0;
            outMagSq     <= '0;
            for (int i = 0; i < COEFF_LENGTH; i++) begin
                coef_re[i] <= '0;
                coef_im[i] <= '0;
                hist_re[i] <= '0;
                hist_im[i] <= '0;
            end
        end else begin
            outValid <= 1'b0;
            if (coeffLoad) begin
                state        <= LOAD_COEFF;
                idx          <= '0;
                wr_ptr       <= '0;
                k_cnt        <= '0;
                coeffSetFlag <= 1'b0;
                dataReady    <= 1'b0;
                for (int i = 0; i < COEFF_LENGTH; i++) begin
                    hist_re[i] <= '0;
                    hist_im[i] <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                    end
                    LOAD_COEFF: begin
                        if (coeffValid) begin
                            coef_re[idx] <= coeffInRe;
                            coef_im[idx] <= coeffInIm;
                            if (idx == LAST) begin
                                idx          <= '0;
                                state        <= WAIT_DATA;
                                coeffSetFlag <= 1'b1;
                                dataReady    <= 1'b1;
                            end else begin
                                idx <= idx + PTR_W'(1);
                            end
                        end
                    end
                    WAIT_DATA: begin
                        if (dataValid) begin
                            hist_re[wr_ptr] <= dataInRe;
                            hist_im[wr_ptr] <= dataInIm;
                            rd_ptr          <= wr_ptr;
                            k_cnt           <= '0;
                            state           <= MAC;
                            dataReady       <= 1'b0;
                        end
                    end
                    MAC: begin
                        // Walk back through the history from the newest sample.
                        rd_ptr <= (rd_ptr == '0) ? LAST : rd_ptr - PTR_W'(1);
                        k_cnt  <= k_cnt + PTR_W'(1);
                        if (k_cnt == LAST) begin
                            state <= MAG;
                        end
                    end
                    MAG: begin
                        outRe     <= acc_re;
                        outIm     <= acc_im;
                        outMagSq  <= mag_sq;
                        outValid  <= 1'b1;
                        wr_ptr    <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
                        state     <= WAIT_DATA;
                        dataReady <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef MF_PEAK_DETECT_EN
    logic [31:0] result_cnt;

    // Strict compare so a tie keeps the earlier index.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            peakMag    <= '0;
            peakIndex  <= '0;
            result_cnt <= '0;
        end else if (coeffLoad) begin
            peakMag    <= '0;
            peakIndex  <= '0;
            result_cnt <= '0;
        end else if (state == MAG) begin
            if (mag_sq > peakMag) begin
                peakMag   <= mag_sq;
                peakIndex <= result_cnt;
            end
            result_cnt <= result_cnt + 32'd1;
        end
    end
`else
    assign peakMag   = '0;
    assign peakIndex = '0;
`endif

endmodule

// File: tb/tb_matched_filter_tdm.sv
// Self-checking bench for matched_filter_tdm: N=4 and N=32 instances share one stimulus bus.
module tb_matched_filter_tdm;

    localparam int DW  = 18;
    localparam int CW  = 18;
    localparam int A4  = DW + CW + 1 + 2;
    localparam int M4  = 2 * A4 + 1;
    localparam int A32 = DW + CW + 1 + 5;
    localparam int M32 = 2 * A32 + 1;
`ifdef MF_PEAK_DETECT_EN
    localparam bit PK = 1'b1;
`else
    localparam bit PK = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                 resetN;
    logic                 coeffLoad;
    logic                 coeffValid;
    logic signed [CW-1:0] coeffInRe;
    logic signed [CW-1:0] coeffInIm;
    logic                 dataValid;
    logic signed [DW-1:0] dataInRe;
    logic signed [DW-1:0] dataInIm;

    logic                  r4_set, r4_ready, r4_valid;
    logic signed [A4-1:0]  r4_re, r4_im;
    logic [M4-1:0]         r4_mag, r4_peak;
    logic [31:0]           r4_pidx;
    logic                  r32_set, r32_ready, r32_valid;
    logic signed [A32-1:0] r32_re, r32_im;
    logic [M32-1:0]        r32_mag, r32_peak;
    logic [31:0]           r32_pidx;

    matched_filter_tdm #(.COEFF_LENGTH(4), .DATA_WIDTH(DW), .COEFF_WIDTH(CW)) dut4 (
        .clock(clock), .resetN(resetN), .coeffLoad(coeffLoad), .coeffValid(coeffValid),
        .coeffInRe(coeffInRe), .coeffInIm(coeffInIm), .coeffSetFlag(r4_set),
        .dataValid(dataValid), .dataReady(r4_ready), .dataInRe(dataInRe), .dataInIm(dataInIm),
        .outValid(r4_valid), .outRe(r4_re), .outIm(r4_im), .outMagSq(r4_mag),
        .peakMag(r4_peak), .peakIndex(r4_pidx)
    );

    matched_filter_tdm #(.COEFF_LENGTH(32), .DATA_WIDTH(DW), .COEFF_WIDTH(CW)) dut32 (
        .clock(clock), .resetN(resetN), .coeffLoad(coeffLoad), .coeffValid(coeffValid),
        .coeffInRe(coeffInRe), .coeffInIm(coeffInIm), .coeffSetFlag(r32_set),
        .dataValid(dataValid), .dataReady(r32_ready), .dataInRe(dataInRe), .dataInIm(dataInIm),
        .outValid(r32_valid), .outRe(r32_re), .outIm(r32_im), .outMagSq(r32_mag),
        .peakMag(r32_peak), .peakIndex(r32_pidx)
    );

    // Observed view of whichever instance is under test.
    logic               sel32;
    logic               obs_set, obs_ready, obs_valid;
    logic signed [63:0] obs_re, obs_im;
    logic [127:0]       obs_mag, obs_peak;
    logic [31:0]        obs_pidx;

    always_comb begin
        obs_set   = sel32 ? r32_set : r4_set;
        obs_ready = sel32 ? r32_ready : r4_ready;
        obs_valid = sel32 ? r32_valid : r4_valid;
        obs_re    = sel32 ? 64'(r32_re) : 64'(r4_re);
        obs_im    = sel32 ? 64'(r32_im) : 64'(r4_im);
        obs_mag   = sel32 ? 128'(r32_mag) : 128'(r4_mag);
        obs_peak  = sel32 ? 128'(r32_peak) : 128'(r4_peak);
        obs_pidx  = sel32 ? r32_pidx : r4_pidx;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    // Reference model: y[n] = sum_k h[k] * x[n-k], x before the last load is zero.
    typedef struct {
        int re;
        int im;
    } cpx_t;

    int           mn;
    int           h_re [32];
    int           h_im [32];
    cpx_t         hist [$];
    logic [127:0] pk_mag;
    int           pk_idx;
    int           res_cnt;

    function automatic void model_result(output logic signed [63:0] er,
                                         output logic signed [63:0] ei,
                                         output logic [127:0] em);
        longint             sr;
        longint             si;
        longint             xr;
        longint             xi;
        logic signed [127:0] a;
        logic signed [127:0] b;
        sr = 0;
        si = 0;
        for (int k = 0; k < mn; k++) begin
            xr = 0;
            xi = 0;
            if (k < hist.size()) begin
                xr = hist[k].re;
                xi = hist[k].im;
            end
            sr += longint'(h_re[k]) * xr - longint'(h_im[k]) * xi;
            si += longint'(h_re[k]) * xi + longint'(h_im[k]) * xr;
        end
        er = sr;
        ei = si;
        a  = 128'(sr);
        b  = 128'(si);
        em = a * a + b * b;
    endfunction

    task automatic load_coeffs(input bit pulse);
        @(negedge clock);
        if (pulse) begin
            // A beat presented with coeffLoad must be dropped.
            coeffLoad  = 1'b1;
            coeffValid = 1'b1;
            coeffInRe  = 18'sh15555;
            coeffInIm  = 18'sh0aaaa;
            @(negedge clock);
            coeffLoad = 1'b0;
        end
        for (int i = 0; i < mn; i++) begin
            coeffValid = 1'b1;
            coeffInRe  = CW'(h_re[i]);
            coeffInIm  = CW'(h_im[i]);
            @(negedge clock);
        end
        coeffValid = 1'b0;
        hist.delete();
        res_cnt = 0;
        pk_mag  = '0;
        pk_idx  = 0;
        check("coeff_set", 128'(obs_set), 128'(1));
    endtask

    task automatic send_sample(input int xr, input int xi,
                               output logic signed [63:0] ore,
                               output logic signed [63:0] oim,
                               output logic [127:0] omag);
        int                 n_wait;
        int                 acc_cyc;
        int                 ready_hi;
        bit                 got;
        logic signed [63:0] er;
        logic signed [63:0] ei;
        logic [127:0]       em;
        n_wait = 0;
        ore    = '0;
        oim    = '0;
        omag   = '0;
        @(negedge clock);
        while (!obs_ready && n_wait < 300) begin
            @(negedge clock);
            n_wait++;
        end
        check("ready_wait", 128'(obs_ready), 128'(1));
        if (!obs_ready) return;
        dataValid = 1'b1;
        dataInRe  = DW'(xr);
        dataInIm  = DW'(xi);
        acc_cyc   = cyc;
        hist.push_front('{re: xr, im: xi});
        if (hist.size() > mn) void'(hist.pop_back());
        @(negedge clock);
        dataValid = 1'b0;
        got       = 1'b0;
        ready_hi  = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (obs_valid) begin
                got = 1'b1;
            end else begin
                if (obs_ready) ready_hi++;
                @(negedge clock);
            end
        end
        check("out_timeout", 128'(got), 128'(1));
        if (!got) return;
        check("latency", 128'(cyc - acc_cyc), 128'(mn + 2));
        check("ready_low_window", 128'(ready_hi), 128'(0));
        model_result(er, ei, em);
        if (em > pk_mag) begin
            pk_mag = em;
            pk_idx = res_cnt;
        end
        res_cnt++;
        check("out_re", 128'(obs_re), 128'(er));
        check("out_im", 128'(obs_im), 128'(ei));
        check("out_mag", obs_mag, em);
        check("peak_mag", obs_peak, PK ? pk_mag : 128'(0));
        check("peak_idx", 128'(obs_pidx), PK ? 128'(pk_idx) : 128'(0));
        ore  = obs_re;
        oim  = obs_im;
        omag = obs_mag;
    endtask

    function automatic int rnd_s18();
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    typedef struct {
        int xr;
        int xi;
        int er;
        int ei;
        int em;
        int pk;
        int pi;
    } vec_t;

    vec_t tab1 [4];
    vec_t tab2 [4];

    initial begin
        #400000;
        $display("watchdog expired at cycle %0d", cyc);
        $fatal(1, "simulation did not complete");
    end

    initial begin
        logic signed [63:0] ore;
        logic signed [63:0] oim;
        logic [127:0]       omag;
        int                 acc_cyc;
        int                 cnt;

        // h = [1+1j, 0, 0, 2]; x = 1, 2j, 0, 0
        tab1[0] = '{1, 0, 1, 1, 2, 2, 0};
        tab1[1] = '{0, 2, -2, 2, 8, 8, 1};
        tab1[2] = '{0, 0, 0, 0, 0, 8, 1};
        tab1[3] = '{0, 0, 2, 0, 4, 8, 1};
        // h = delta; magnitudes 4, 9, 9, 1 (tie keeps index 1)
        tab2[0] = '{2, 0, 2, 0, 4, 4, 0};
        tab2[1] = '{3, 0, 3, 0, 9, 9, 1};
        tab2[2] = '{0, 3, 0, 3, 9, 9, 1};
        tab2[3] = '{1, 0, 1, 0, 1, 9, 1};

        sel32      = 1'b0;
        resetN     = 1'b0;
        coeffLoad  = 1'b0;
        coeffValid = 1'b0;
        coeffInRe  = '0;
        coeffInIm  = '0;
        dataValid  = 1'b0;
        dataInRe   = '0;
        dataInIm   = '0;
        mn         = 4;
        pk_mag     = '0;
        pk_idx     = 0;
        res_cnt    = 0;
        for (int i = 0; i < 32; i++) begin
            h_re[i] = 0;
            h_im[i] = 0;
        end

        repeat (3) @(negedge clock);
        check("rst_valid", 128'(obs_valid), 128'(0));
        check("rst_re", 128'(obs_re), 128'(0));
        check("rst_im", 128'(obs_im), 128'(0));
        check("rst_mag", obs_mag, 128'(0));
        check("rst_ready", 128'(obs_ready), 128'(0));
        check("rst_set", 128'(obs_set), 128'(0));
        check("rst_peak", obs_peak, 128'(0));
        check("rst_pidx", 128'(obs_pidx), 128'(0));
        resetN = 1'b1;

        // Table 1: mixed complex taps
        h_re[0] = 1; h_im[0] = 1; h_re[3] = 2;
        load_coeffs(1'b1);
        for (int i = 0; i < 4; i++) begin
            send_sample(tab1[i].xr, tab1[i].xi, ore, oim, omag);
            check("t1_re", 128'(ore), 128'(tab1[i].er));
            check("t1_im", 128'(oim), 128'(tab1[i].ei));
            check("t1_mag", omag, 128'(tab1[i].em));
            check("t1_peak", obs_peak, PK ? 128'(tab1[i].pk) : 128'(0));
            check("t1_pidx", 128'(obs_pidx), PK ? 128'(tab1[i].pi) : 128'(0));
        end

        // Table 2: delta taps, peak tracking
        for (int i = 0; i < 4; i++) begin
            h_re[i] = 0;
            h_im[i] = 0;
        end
        h_re[0] = 1;
        load_coeffs(1'b1);
        for (int i = 0; i < 4; i++) begin
            send_sample(tab2[i].xr, tab2[i].xi, ore, oim, omag);
            check("t2_re", 128'(ore), 128'(tab2[i].er));
            check("t2_im", 128'(oim), 128'(tab2[i].ei));
            check("t2_mag", omag, 128'(tab2[i].em));
            check("t2_peak", obs_peak, PK ? 128'(tab2[i].pk) : 128'(0));
            check("t2_pidx", 128'(obs_pidx), PK ? 128'(tab2[i].pi) : 128'(0));
        end

        load_coeffs(1'b1);
        send_sample(5, 3, ore, oim, omag);
        check("delta_re", 128'(ore), 128'(5));
        check("delta_im", 128'(oim), 128'(3));
        check("delta_mag", omag, 128'(34));

        // coeffValid outside LOAD_COEFF must not disturb the taps
        @(negedge clock);
        coeffValid = 1'b1;
        coeffInRe  = 18'sh1f0f0;
        coeffInIm  = 18'sh00f0f;
        repeat (2) @(negedge clock);
        coeffValid = 1'b0;
        send_sample(-7, 11, ore, oim, omag);
        check("stray_beat_re", 128'(ore), 128'(-7));

        // Abort on MAC cycle 2
        for (int i = 0; i < 4; i++) begin
            h_re[i] = 0;
            h_im[i] = 0;
        end
        h_re[0] = 1; h_im[0] = 1; h_re[3] = 2;
        load_coeffs(1'b1);
        send_sample(1, 0, ore, oim, omag);
        @(negedge clock);
        check("abort_ready", 128'(obs_ready), 128'(1));
        dataValid = 1'b1;
        dataInRe  = 18'sd0;
        dataInIm  = 18'sd2;
        acc_cyc   = cyc;
        @(negedge clock);
        dataValid = 1'b0;
        @(negedge clock);
        coeffLoad = 1'b1;
        @(negedge clock);
        coeffLoad = 1'b0;
        check("abort_set", 128'(obs_set), 128'(0));
        check("abort_ready_low", 128'(obs_ready), 128'(0));
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (obs_valid) cnt++;
            @(negedge clock);
        end
        check("abort_no_out", 128'(cnt), 128'(0));
        load_coeffs(1'b0);
        send_sample(1, 0, ore, oim, omag);
        check("abort_fresh_re", 128'(ore), 128'(1));
        check("abort_fresh_im", 128'(oim), 128'(1));

        // Random taps and samples, N=4
        for (int i = 0; i < 4; i++) begin
            h_re[i] = rnd_s18();
            h_im[i] = rnd_s18();
        end
        load_coeffs(1'b1);
        for (int i = 0; i < 20; i++) begin
            send_sample(rnd_s18(), rnd_s18(), ore, oim, omag);
        end

        // Full-scale, N=32: every term is (2^17)^2 * 2j
        sel32 = 1'b1;
        mn    = 32;
        for (int i = 0; i < 32; i++) begin
            h_re[i] = -131072;
            h_im[i] = -131072;
        end
        load_coeffs(1'b1);
        for (int i = 0; i < 33; i++) begin
            send_sample(-131072, -131072, ore, oim, omag);
        end
        check("fs_re", 128'(ore), 128'(0));
        check("fs_im", 128'(oim), 128'(64'sd1 << 40));
        check("fs_mag", omag, 128'(1) << 80);

        // Reset in the middle of a MAC pass, N=32
        for (int i = 0; i < 32; i++) begin
            h_re[i] = rnd_s18();
            h_im[i] = rnd_s18();
        end
        load_coeffs(1'b1);
        send_sample(rnd_s18(), rnd_s18(), ore, oim, omag);
        @(negedge clock);
        dataValid = 1'b1;
        dataInRe  = 18'sd100;
        dataInIm  = -18'sd50;
        @(negedge clock);
        dataValid = 1'b0;
        repeat (5) @(negedge clock);
        resetN = 1'b0;
        #2;
        check("mrst_valid", 128'(obs_valid), 128'(0));
        check("mrst_re", 128'(obs_re), 128'(0));
        check("mrst_im", 128'(obs_im), 128'(0));
        check("mrst_mag", obs_mag, 128'(0));
        check("mrst_ready", 128'(obs_ready), 128'(0));
        check("mrst_set", 128'(obs_set), 128'(0));
        check("mrst_peak", obs_peak, 128'(0));
        check("mrst_pidx", 128'(obs_pidx), 128'(0));
        @(negedge clock);
        resetN = 1'b1;
        cnt      = 0;
        acc_cyc  = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (obs_valid) cnt++;
            if (obs_ready) acc_cyc++;
        end
        check("mrst_no_out", 128'(cnt), 128'(0));
        check("mrst_idle_ready", 128'(acc_cyc), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
